// File: rtl/mips_mem_responder.sv
// mips_mem_responder: boot-loaded instruction memory plus data memory serving a MIPS core.
// Clears DMEM, accepts an IMEM image over a valid/ready port, then releases the CPU.
// Define DMEM_ACCESS_ERR_EN to add a sticky access_err flag (with err_clr) for
// misaligned or out-of-range data accesses.
module mips_mem_responder #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_adr,
    output logic [31:0] inst,
    input  logic [31:0] data_adr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_rst,
    output logic        boot_done
`ifdef DMEM_ACCESS_ERR_EN
    ,
    output logic        access_err,
    input  logic        err_clr
`endif
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

    state_t          state, next_state;
    logic [IW-1:0]   ld_cnt;
    logic [DW-1:0]   clr_cnt;
    logic [31:0]     imem [IMEM_DEPTH];
    logic [31:0]     dmem [DMEM_DEPTH];
    logic [IW-1:0]   i_idx;
    logic [DW-1:0]   d_idx;
    logic            i_oor, d_oor;
    logic            load_acc, dmem_we;
    logic            unused_bits;

    assign i_idx       = inst_adr[IW+1:2];
    assign d_idx       = data_adr[DW+1:2];
    assign i_oor       = |inst_adr[31:IW+2];
    assign d_oor       = |data_adr[31:DW+2];
    assign load_acc    = state == LOAD && load_valid;
    assign dmem_we     = state == RUN && mem_write && !d_oor;
    assign unused_bits = ^{inst_adr[1:0], data_adr[1:0]};

    // State register; CPU reset and boot status move in the same cycle as the state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= CLEAR;
            cpu_rst   <= 1'b1;
            boot_done <= 1'b0;
        end else begin
            state     <= next_state;
            cpu_rst   <= next_state != RUN;
            boot_done <= next_state == RUN;
        end
    end

    // Next state: CLEAR sweeps every DMEM word, LOAD ends on last word or a full IMEM
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   next_state = clr_cnt == DW'(DMEM_DEPTH - 1) ? LOAD : CLEAR;
            LOAD:    next_state = load_acc && (load_last || ld_cnt == IW'(IMEM_DEPTH - 1)) ? RUN : LOAD;
            RUN:     next_state = RUN;
            default: next_state = CLEAR;
        endcase
    end

    // Outputs: memories are only visible to the CPU once running
    always_comb begin
        load_ready = state == LOAD;
        inst       = state == RUN && !i_oor ? imem[i_idx] : '0;
        data_in    = state == RUN && mem_read && !d_oor ? dmem[d_idx] : '0;
    end

    // Clear sweep address and image word counter, both restarting from zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_cnt <= '0;
            ld_cnt  <= '0;
        end else begin
            clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
            ld_cnt  <= state == CLEAR ? '0 : load_acc ? ld_cnt + 1'b1 : ld_cnt;
        end
    end

    // Boot image words land in IMEM only while loading
    always_ff @(posedge clk) begin
        if (rst && load_acc)
            imem[ld_cnt] <= load_data;
    end

    // DMEM is zero-filled during CLEAR and takes CPU stores in RUN
    always_ff @(posedge clk) begin
        if (rst && state == CLEAR)
            dmem[clr_cnt] <= '0;
        else if (rst && dmem_we)
            dmem[d_idx] <= data_out;
    end

`ifdef DMEM_ACCESS_ERR_EN
    // Sticky error on bad data accesses; a new error beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst)
            access_err <= 1'b0;
        else if (state == RUN && (mem_read || mem_write) && (data_adr[1:0] != 2'b00 || d_oor))
            access_err <= 1'b1;
        else if (err_clr)
            access_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: random and directed checks against a behavioural memory-responder model.
module tb_mips_mem_responder;
    localparam int ID = 32;
    localparam int DD = 64;
    localparam int P_CLEAR = 0;
    localparam int P_LOAD  = 1;
    localparam int P_RUN   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_adr = '0, data_adr = '0, data_out = '0, load_data = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [31:0] inst, data_in;
    logic        load_ready, cpu_rst, boot_done;
`ifdef DMEM_ACCESS_ERR_EN
    logic        err_clr = 1'b0;
    logic        access_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_known = 1'b0;
    int          m_phase = P_CLEAR;
    int          m_nclr  = 0;
    int          m_nld   = 0;
    logic [31:0] m_imem [ID];
    bit          m_iv   [ID];
    logic [31:0] m_dmem [DD];
    bit          m_err   = 1'b0;

    mips_mem_responder #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD)) dut (
        .clk(clk), .rst(rst),
        .inst_adr(inst_adr), .inst(inst),
        .data_adr(data_adr), .data_out(data_out), .data_in(data_in),
        .mem_read(mem_read), .mem_write(mem_write),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .cpu_rst(cpu_rst), .boot_done(boot_done)
`ifdef DMEM_ACCESS_ERR_EN
        , .access_err(access_err), .err_clr(err_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w, input logic last);
        load_valid = 1'b1;
        load_data  = w;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reset_clear();
        int n;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        n = 0;
        while (!load_ready && n < DD + 8) begin
            step();
            n++;
        end
        check("clear_cycles", n, DD);
        check("cpu_rst_in_load", cpu_rst, 1);
    endtask

    function automatic logic [31:0] rand_dadr();
        case ($urandom_range(0, 4))
            0, 1, 2: return $urandom_range(0, 15) * 4;
            3:       return $urandom_range(0, DD * 4 - 1);
            default: return $urandom_range(0, 1) ? DD * 4 + $urandom_range(0, 255)
                                                 : 32'hFFFF_FFF0 | $urandom_range(0, 15);
        endcase
    endfunction

    // Reference model: phase, words cleared, words loaded, memory images by word index
    always @(posedge clk) begin
        if (!rst) begin
            m_known <= 1'b1;
            m_phase <= P_CLEAR;
            m_nclr  <= 0;
            m_nld   <= 0;
            m_err   <= 1'b0;
        end else if (m_known) begin
            if (m_phase == P_CLEAR) begin
                m_dmem[m_nclr] <= '0;
                m_nclr <= m_nclr + 1;
                m_nld  <= 0;
                if (m_nclr + 1 == DD) m_phase <= P_LOAD;
            end else if (m_phase == P_LOAD && load_valid) begin
                m_imem[m_nld] <= load_data;
                m_iv[m_nld]   <= 1'b1;
                m_nld <= m_nld + 1;
                if (load_last || m_nld + 1 == ID) m_phase <= P_RUN;
            end else if (m_phase == P_RUN && mem_write && data_adr < DD * 4) begin
                m_dmem[data_adr / 4] <= data_out;
            end
`ifdef DMEM_ACCESS_ERR_EN
            if (m_phase == P_RUN && (mem_read || mem_write) && (data_adr % 4 != 0 || data_adr >= DD * 4))
                m_err <= 1'b1;
            else if (err_clr)
                m_err <= 1'b0;
`endif
        end
    end

    // Compare every cycle once the model state is known
    always @(negedge clk) begin
        if (m_known) begin
            check("cpu_rst", cpu_rst, m_phase != P_RUN);
            check("boot_done", boot_done, m_phase == P_RUN);
            check("load_ready", load_ready, m_phase == P_LOAD);
            if (m_phase != P_RUN || inst_adr >= ID * 4)
                check("inst_zero", inst, 0);
            else if (m_iv[inst_adr / 4])
                check("inst", inst, m_imem[inst_adr / 4]);
            if (m_phase == P_RUN && mem_read && data_adr < DD * 4)
                check("data_in", data_in, m_dmem[data_adr / 4]);
            else
                check("data_in_zero", data_in, 0);
`ifdef DMEM_ACCESS_ERR_EN
            check("access_err", access_err, m_err);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached, bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] last_w;
        do_reset_clear();

        load_word(32'h20080005, 1'b0);
        load_word(32'h20090007, 1'b0);
        load_word(32'h01095020, 1'b1);
        check("boot_cpu_rst", cpu_rst, 0);
        check("boot_done", boot_done, 1);
        check("boot_load_ready", load_ready, 0);
        inst_adr = 32'h8;
        #1 check("inst_at_8", inst, 32'h01095020);
        inst_adr = 32'h5;
        #1 check("inst_at_5", inst, 32'h20090007);

        data_adr  = 32'h10;
        data_out  = 32'hDEADBEEF;
        mem_write = 1'b1;
        mem_read  = 1'b1;
        #1 check("read_during_write", data_in, 32'h0);
        step();
        mem_write = 1'b0;
        #1 check("read_after_write", data_in, 32'hDEADBEEF);
        mem_read = 1'b0;

        for (int i = 0; i < 400; i++) begin
            inst_adr   = $urandom_range(0, 1) ? $urandom_range(0, ID * 4 + 31) : $urandom;
            data_adr   = rand_dadr();
            data_out   = $urandom;
            mem_read   = $urandom_range(0, 1);
            mem_write  = $urandom_range(0, 2) == 0;
            load_valid = $urandom_range(0, 1);
            load_data  = $urandom;
`ifdef DMEM_ACCESS_ERR_EN
            err_clr    = $urandom_range(0, 7) == 0;
`endif
            step();
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        load_valid = 1'b0;
`ifdef DMEM_ACCESS_ERR_EN
        err_clr = 1'b0;
`endif

        data_adr  = 32'h20;
        data_out  = 32'h55;
        mem_write = 1'b1;
        step();
        mem_write = 1'b0;
        mem_read  = 1'b1;
        #1 check("stored_55", data_in, 32'h55);
        mem_read = 1'b0;
        do_reset_clear();
        load_word(32'h20080005, 1'b1);
        check("reboot_done", boot_done, 1);
        inst_adr = 32'h8;
        #1 check("imem_kept", inst, 32'h01095020);
        data_adr = 32'h20;
        mem_read = 1'b1;
        #1 check("dmem_cleared", data_in, 32'h0);
        mem_read = 1'b0;

        do_reset_clear();
        last_w = '0;
        for (int i = 0; i < ID + 2; i++) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            if (i == ID - 1) last_w = load_data;
            check("stream_ready", load_ready, i < ID);
            step();
            if (i == ID - 2) check("stream_not_run", boot_done, 0);
            if (i == ID - 1) check("stream_run", boot_done, 1);
        end
        load_valid = 1'b0;
        inst_adr = (ID - 1) * 4;
        #1 check("inst_last_word", inst, last_w);

`ifdef DMEM_ACCESS_ERR_EN
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_idle", access_err, 0);
        data_adr = 32'h13;
        mem_read = 1'b1;
        step();
        mem_read = 1'b0;
        check("err_set", access_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_cleared", access_err, 0);
        err_clr  = 1'b1;
        mem_read = 1'b1;
        step();
        err_clr  = 1'b0;
        mem_read = 1'b0;
        check("err_set_wins", access_err, 1);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256: instruction-memory depth in 32-bit words, power of two.
REQ-002 SHALL have parameter DMEM_DEPTH, default 256: data-memory depth in 32-bit words, power of two.
REQ-003 SHALL have one clock and a synchronous, active-low reset:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
REQ-004 SHALL have the CPU instruction port:
- inst_adr  input  32  CPU instruction byte address.
- inst  output  32  instruction word.
REQ-005 SHALL have the CPU data port:
- data_adr  input  32  data byte address.
- data_out  input  32  CPU store data.
- data_in  output  32  load data to the CPU.
- mem_read  input  1  load request.
- mem_write  input  1  store request.
REQ-006 SHALL have the boot-load port:
- load_valid  input  1  load_data is valid.
- load_data  input  32  instruction word to load.
- load_last  input  1  final word of the image.
- load_ready  output  1  the block accepts a word this cycle.
REQ-007 SHALL have the status outputs:
- cpu_rst  output  1  active-high reset for the CPU.
- boot_done  output  1  the block is in RUN.

Function
REQ-008 SHALL use word index adr[log2(DEPTH)+1:2]; adr[1:0] SHALL be ignored; any set bit above the index range SHALL mark the access out of range.
REQ-009 SHALL drive inst combinationally from IMEM[index(inst_adr)] in RUN; out of range SHALL read 32'h0.
REQ-010 SHALL drive data_in combinationally as DMEM[index(data_adr)] when mem_read=1 in RUN, otherwise 32'h0; out of range SHALL read 32'h0.
REQ-011 SHALL write data_out into DMEM at the clock edge when mem_write=1 in RUN and the address is in range; out-of-range writes SHALL be dropped.
REQ-012 A read of an address in the same cycle as a write to it SHALL return the old value; the new value SHALL be visible from the next cycle.
REQ-013 SHALL implement an FSM with states CLEAR, LOAD and RUN.
REQ-014 CLEAR: SHALL write 0 to DMEM[clr_cnt] with clr_cnt counting 0..DMEM_DEPTH-1, one word per cycle, then go to LOAD; it SHALL take exactly DMEM_DEPTH cycles.
REQ-015 LOAD: load_ready=1; on load_valid&load_ready, SHALL write load_data to IMEM[ld_cnt] and increment ld_cnt, which starts at 0 on entry to LOAD.
REQ-016 LOAD SHALL go to RUN after accepting a word with load_last=1, or after accepting the word at ld_cnt=IMEM_DEPTH-1, whichever comes first.
REQ-017 RUN: load_ready=0, load_valid SHALL be ignored, and the block SHALL stay in RUN until reset.
REQ-018 cpu_rst=1 in CLEAR and LOAD and 0 in RUN; boot_done=~cpu_rst; both SHALL be registered and change in the cycle the state changes.
REQ-019 Outside RUN, CPU port writes SHALL be ignored and inst/data_in SHALL be 0.

Reset
REQ-020 rst=0 at a clock edge SHALL set state=CLEAR and clr_cnt=ld_cnt=0, and SHALL give cpu_rst=1, boot_done=0, load_ready=0, inst=0, data_in=0.
REQ-021 Reset in any state, including mid-LOAD or mid-RUN, SHALL restart at CLEAR; IMEM contents SHALL NOT be reset; DMEM SHALL be zeroed by CLEAR.

Configuration
REQ-022 With macro DMEM_ACCESS_ERR_EN defined, the block SHALL add output access_err (1 bit) and input err_clr (1 bit):
- access_err SHALL be set sticky in RUN by any mem_read or mem_write with data_adr[1:0]!=0 or out of range.
- err_clr=1 or reset SHALL clear access_err to 0.
- If set and clear occur in the same cycle, set SHALL win.
REQ-023 Without DMEM_ACCESS_ERR_EN, these ports and the sticky logic SHALL be absent; behaviour SHALL otherwise be identical.

Verification
REQ-024 The bench SHALL check: release reset, hold load_valid=0 -> load_ready rises exactly DMEM_DEPTH cycles after reset release; cpu_rst stays 1.
REQ-025 The bench SHALL check: load 3 words 0x20080005, 0x20090007, 0x01095020 with load_last on the third -> next cycle cpu_rst=0, boot_done=1; inst_adr=8 gives inst=0x01095020.
REQ-026 The bench SHALL check: in RUN, mem_write with data_adr=0x10 and data_out=0xDEADBEEF, then mem_read at 0x10 -> data_in=0xDEADBEEF; a read in the same write cycle -> 0x0.
REQ-027 The bench SHALL check: stream IMEM_DEPTH+2 words without load_last -> RUN entered after word IMEM_DEPTH-1; the last two words are not accepted (load_ready=0).
REQ-028 The bench SHALL check: assert reset mid-RUN after storing 0x55 at 0x20 -> after CLEAR, data 0x20 reads 0; IMEM content unchanged.
REQ-029 The bench SHALL check, with DMEM_ACCESS_ERR_EN: mem_read at 0x13 -> access_err=1 next cycle; err_clr pulse -> 0; err_clr together with a bad access -> access_err stays 1.
